cmd_bus_tx: RTL

- Transmit side of the 3-bit strobed command bus (C0..C2 data, CLK strobe); the controller samples data on the falling edge of its filtered CLK.
- Accepts one command per valid/ready handshake and serialises it into 1, 2 or 4 bus symbols with programmable setup, high, hold and inter-command gap times.
- Sits in the host-side FPGA and drives the cable to the converter controller.
- Timing parameters are sized to exceed the receiver's input filter depth and its output-update wait states.

---
 rtl/cmd_bus_pkg.sv | 43 ++++
 rtl/cmd_bus_tx_if.sv | 25 ++
 rtl/cmd_bus_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cmd_bus_pkg.sv
// Shared command-bus definitions: command codes, transmitter states and the
// code-to-symbol mapping used by both the transmitter and the receiver decode.
package cmd_bus_pkg;

    typedef enum logic [2:0] {
        CMD_PAUSE     = 3'd0,
        CMD_PLUS      = 3'd1,
        CMD_MINUS     = 3'd2,
        CMD_BALLAST_P = 3'd3,
        CMD_BALLAST_N = 3'd4,
        CMD_START     = 3'd5,
        CMD_SHUTDOWN  = 3'd6,
        CMD_DISCHARGE = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_t;

    localparam int SYM_IDX_W = 2;

    function automatic logic [2:0] seq_len(input cmd_t c);
        case (c)
            CMD_START:     return 3'd2;
            CMD_DISCHARGE: return 3'd4;
            default:       return 3'd1;
        endcase
    endfunction

    // START is followed by a zero symbol; DISCHARGE alternates 7/0 twice.
    function automatic logic [2:0] seq_sym(input cmd_t c, input logic [SYM_IDX_W-1:0] idx);
        case (c)
            CMD_START:     return (idx == 2'd0) ? 3'd5 : 3'd0;
            CMD_DISCHARGE: return idx[0] ? 3'd0 : 3'd7;
            default:       return c;
        endcase
    endfunction

endpackage

// File: rtl/cmd_bus_tx_if.sv
// Host-side command handshake plus the physical strobed bus outputs.
interface cmd_bus_tx_if;
    import cmd_bus_pkg::*;

    logic       cmd_valid;
    cmd_t       cmd;
    logic       abort;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       o_clk;
    logic [2:0] o_bus;

    modport master (
        output cmd_valid, cmd, abort,
        input  cmd_ready, busy, done, aborted, o_clk, o_bus
    );

    modport slave (
        input  cmd_valid, cmd, abort,
        output cmd_ready, busy, done, aborted, o_clk, o_bus
    );

endinterface

// File: rtl/cmd_bus_tx.sv
// Serialises one command into 1, 2 or 4 strobed bus symbols with programmable
// setup/high/hold timing and an inter-command gap. All outputs are registered.
module cmd_bus_tx
    import cmd_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = 16,
    parameter int HIGH_CYCLES  = 16,
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 32
) (
    input  logic          clk,
    input  logic          rstn,
    cmd_bus_tx_if.slave   bus
);

    localparam int MAX_SH  = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_SH > MAX_HG) ? MAX_SH : MAX_HG;
    localparam int CNT_W   = ($clog2(MAX_ALL) > 0) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    tx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    cmd_t                   cmd_q, cmd_d;
    logic [SYM_IDX_W-1:0]   idx_q, idx_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   o_clk_q, o_clk_d;
    logic [2:0]             o_bus_q, o_bus_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    logic                   abort_now;
    logic                   pend;
    logic                   last_sym;
    logic                   cnt_zero;

    assign abort_now = bus.abort && (state_q != ST_IDLE);
    assign pend      = abort_pend_q || abort_now;
    assign last_sym  = ((3'(idx_q) + 3'd1) == seq_len(cmd_q));
    assign cnt_zero  = (cnt_q == CNT_ZERO);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        idx_d        = idx_q;
        abort_pend_d = pend;
        o_clk_d      = o_clk_q;
        o_bus_d      = o_bus_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_clk_d      = 1'b0;
                o_bus_d      = 3'd0;
                abort_pend_d = 1'b0;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_d       = bus.cmd;
                    idx_d       = '0;
                    o_bus_d     = seq_sym(bus.cmd, '0);
                    cnt_d       = SETUP_LOAD;
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    o_clk_d = 1'b1;
                    cnt_d   = HIGH_LOAD;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    o_clk_d = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Abort is only honoured here so a started strobe always finishes.
                if (cnt_zero) begin
                    if (last_sym || pend) begin
                        o_bus_d = 3'd0;
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        o_bus_d = seq_sym(cmd_q, idx_q + 2'd1);
                        cnt_d   = SETUP_LOAD;
                        state_d = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    done_d       = 1'b1;
                    aborted_d    = pend;
                    abort_pend_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                o_clk_d      = 1'b0;
                o_bus_d      = 3'd0;
                abort_pend_d = 1'b0;
                cmd_ready_d  = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_q        <= CMD_PAUSE;
            idx_q        <= '0;
            abort_pend_q <= 1'b0;
            o_clk_q      <= 1'b0;
            o_bus_q      <= 3'd0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            idx_q        <= idx_d;
            abort_pend_q <= abort_pend_d;
            o_clk_q      <= o_clk_d;
            o_bus_q      <= o_bus_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.o_clk     = o_clk_q;
    assign bus.o_bus     = o_bus_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule
